// File: rtl/exmem_pkg.sv
// -----------------------------------------------------------------------------
// exmem_pkg
// -----------------------------------------------------------------------------
// Shared definitions for the EX/MEM pipeline register and its neighbouring
// pipeline registers (ID/EX, MEM/WB).
//
// Contents:
//   EXMEM_*_W        default field widths (ALU data, destination register,
//                    writeback control, memory control, stall counter)
//   exmem_payload_t  packed view of one EX/MEM entry at the default widths,
//                    ordered {wb, m, rd, alu, data} (MSB first)
//   payload_width()  flat payload width for an arbitrary width set, so that
//                    parametrised instances pack their fields the same way
// -----------------------------------------------------------------------------
package exmem_pkg;

   localparam int EXMEM_DATA_W = 32;
   localparam int EXMEM_RD_W   = 5;
   localparam int EXMEM_WB_W   = 2;
   localparam int EXMEM_M_W    = 3;
   localparam int EXMEM_CNT_W  = 16;

   typedef struct packed {
      logic [EXMEM_WB_W-1:0]   wb;
      logic [EXMEM_M_W-1:0]    m;
      logic [EXMEM_RD_W-1:0]   rd;
      logic [EXMEM_DATA_W-1:0] alu;
      logic [EXMEM_DATA_W-1:0] data;
   } exmem_payload_t;

   localparam int EXMEM_PAYLOAD_W = $bits(exmem_payload_t);

   // Same field order as exmem_payload_t, usable when the widths are
   // overridden by module parameters.
   function automatic int payload_width(input int wb_w, input int m_w,
                                        input int rd_w, input int data_w);
      return wb_w + m_w + rd_w + 2 * data_w;
   endfunction

endpackage

// File: rtl/exmem_slot.sv
// -----------------------------------------------------------------------------
// exmem_slot
// -----------------------------------------------------------------------------
// One storage slot of the EX/MEM register: a payload register plus its valid
// bit. The payload is forced to zero whenever the slot is empty so the
// downstream stage never sees stale data next to a low valid.
//
// Parameters:
//   W        payload width in bits
//
// Ports:
//   i_clk    clock, all updates on posedge
//   i_rst    synchronous active-high reset (empties the slot)
//   i_clear  synchronous flush (empties the slot)
//   i_load   capture i_data and mark the slot valid
//   i_drain  the held entry is consumed this edge (ignored when i_load)
//   i_data   payload to capture
//   o_valid  slot holds an entry
//   o_data   held payload, zero when empty
//
// Priority: reset/clear > load > drain > hold.
// -----------------------------------------------------------------------------
module exmem_slot
   import exmem_pkg::*;
#(
   parameter int W = EXMEM_PAYLOAD_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic         i_drain,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values of its inputs, independent of statement order.
   // NOTE: the payload is reset along with the valid bit on purpose: an empty
   // slot must present all-zero fields, not just a low valid.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_drain) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/exmem_pipe_reg.sv
// -----------------------------------------------------------------------------
// exmem_pipe_reg
// -----------------------------------------------------------------------------
// EX/MEM pipeline register with valid/ready handshake, flush and a saturating
// stall counter. Carries the WB and M control fields, the destination
// register, the ALU result and the store data from the ALU stage to the data
// memory stage. Control fields pass through undecoded.
//
// Build option:
//   EXMEM_SKID_EN  defined   : main slot plus skid slot; o_in_ready depends
//                              only on registered state (no path from
//                              i_out_ready). One extra entry is accepted
//                              after i_out_ready falls.
//                  undefined : single slot; o_in_ready = !out_valid ||
//                              out_ready (combinational).
//
// Parameters: DATA_W, RD_W, WB_W, M_W, CNT_W (field and counter widths).
//
// Ports:
//   i_Clock            clock, all updates on posedge
//   i_Reset            synchronous active-high reset (highest priority)
//   i_Flush            empties all slots at the next edge, drops any
//                      same-cycle input, leaves the stall counter alone
//   i_in_valid         EX stage presents an instruction
//   o_in_ready         register accepts this cycle (0 while i_Reset)
//   i_WB, i_M, i_RD    control fields and destination register
//   i_saidaALU         ALU result
//   i_entradaData      store data
//   o_out_valid        outputs hold a valid instruction
//   i_out_ready        MEM stage consumes this cycle
//   o_registradorWB/M/RD/ALU, o_saidaData
//                      registered payload, zero when o_out_valid=0
//   o_stall_count      saturating count of edges with out_valid && !out_ready
// -----------------------------------------------------------------------------
module exmem_pipe_reg
   import exmem_pkg::*;
#(
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int RD_W   = EXMEM_RD_W,
   parameter int WB_W   = EXMEM_WB_W,
   parameter int M_W    = EXMEM_M_W,
   parameter int CNT_W  = EXMEM_CNT_W
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_Flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [WB_W-1:0]   i_WB,
   input  logic [M_W-1:0]    i_M,
   input  logic [RD_W-1:0]   i_RD,
   input  logic [DATA_W-1:0] i_saidaALU,
   input  logic [DATA_W-1:0] i_entradaData,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [WB_W-1:0]   o_registradorWB,
   output logic [M_W-1:0]    o_registradorM,
   output logic [RD_W-1:0]   o_registradorRD,
   output logic [DATA_W-1:0] o_registradorALU,
   output logic [DATA_W-1:0] o_saidaData,
   output logic [CNT_W-1:0]  o_stall_count
);

   localparam int PL_W = payload_width(WB_W, M_W, RD_W, DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [PL_W-1:0]  w_in_payload;
   logic [PL_W-1:0]  w_main_data;
   logic [PL_W-1:0]  w_main_d;
   logic             w_main_valid;
   logic             w_main_load;
   logic             w_out_fire;
   logic             w_in_fire;
   logic [CNT_W-1:0] r_stall_count;

   // Field order matches exmem_payload_t.
   assign w_in_payload = {i_WB, i_M, i_RD, i_saidaALU, i_entradaData};

   assign w_out_fire = w_main_valid && i_out_ready;
   assign w_in_fire  = i_in_valid && o_in_ready;

`ifdef EXMEM_SKID_EN
   logic            w_skid_valid;
   logic            w_skid_load;
   logic [PL_W-1:0] w_skid_data;

   // A full skid slot is the only reason to refuse input, so ready is a
   // function of registered state (plus reset).
   assign o_in_ready = !i_Reset && !w_skid_valid;

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves one unassigned and no latch is inferred.
   always_comb begin
      w_main_load = 1'b0;
      w_main_d    = w_in_payload;
      w_skid_load = 1'b0;
      if (w_skid_valid) begin
         // Input is blocked; the skid entry refills main as main drains.
         w_main_load = w_out_fire;
         w_main_d    = w_skid_data;
      end else if (w_in_fire) begin
         if (!w_main_valid || w_out_fire) begin
            w_main_load = 1'b1;
         end else begin
            // Main is full and stalled: park the entry in the skid slot.
            w_skid_load = 1'b1;
         end
      end
   end

   exmem_slot #(
      .W       (PL_W)
   ) u_skid (
      .i_clk   (i_Clock),
      .i_rst   (i_Reset),
      .i_clear (i_Flush),
      .i_load  (w_skid_load),
      .i_drain (w_skid_valid && w_out_fire),
      .i_data  (w_in_payload),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data)
   );
`else
   // Accept when empty or when the held entry leaves at this same edge.
   assign o_in_ready = !i_Reset && (!w_main_valid || i_out_ready);

   always_comb begin
      w_main_load = w_in_fire;
      w_main_d    = w_in_payload;
   end
`endif

   exmem_slot #(
      .W       (PL_W)
   ) u_main (
      .i_clk   (i_Clock),
      .i_rst   (i_Reset),
      .i_clear (i_Flush),
      .i_load  (w_main_load),
      .i_drain (w_out_fire),
      .i_data  (w_main_d),
      .o_valid (w_main_valid),
      .o_data  (w_main_data)
   );

   // Counts edges where MEM holds off a valid entry; saturates at all-ones.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_stall_count <= '0;
      end else if (!i_Flush && w_main_valid && !i_out_ready &&
                   (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + CNT_ONE;
      end
   end

   assign o_out_valid   = w_main_valid;
   assign o_stall_count = r_stall_count;
   assign {o_registradorWB, o_registradorM, o_registradorRD,
           o_registradorALU, o_saidaData} = w_main_data;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_exmem_pipe_reg
// -----------------------------------------------------------------------------
// Drives two instances (CNT_W=16 and CNT_W=4) with identical stimulus and
// compares them against a queue-based reference: the register is a FIFO of
// capacity 1 (or 2 with EXMEM_SKID_EN) whose head is shown on the outputs.
// -----------------------------------------------------------------------------
module tb_exmem_pipe_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] data;
   } pl_t;

`ifdef EXMEM_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic flush     = 1'b0;
   logic in_valid  = 1'b0;
   logic out_ready = 1'b0;
   pl_t  in_pl     = '0;

   logic        ir16, ov16, ir4, ov4;
   logic [1:0]  wb16, wb4;
   logic [2:0]  m16, m4;
   logic [4:0]  rd16, rd4;
   logic [31:0] alu16, alu4, dat16, dat4;
   logic [15:0] st16;
   logic [3:0]  st4;

   exmem_pipe_reg u_dut (
      .i_Clock          (clk),
      .i_Reset          (rst),
      .i_Flush          (flush),
      .i_in_valid       (in_valid),
      .o_in_ready       (ir16),
      .i_WB             (in_pl.wb),
      .i_M              (in_pl.m),
      .i_RD             (in_pl.rd),
      .i_saidaALU       (in_pl.alu),
      .i_entradaData    (in_pl.data),
      .o_out_valid      (ov16),
      .i_out_ready      (out_ready),
      .o_registradorWB  (wb16),
      .o_registradorM   (m16),
      .o_registradorRD  (rd16),
      .o_registradorALU (alu16),
      .o_saidaData      (dat16),
      .o_stall_count    (st16)
   );

   exmem_pipe_reg #(.CNT_W(4)) u_dut_c4 (
      .i_Clock          (clk),
      .i_Reset          (rst),
      .i_Flush          (flush),
      .i_in_valid       (in_valid),
      .o_in_ready       (ir4),
      .i_WB             (in_pl.wb),
      .i_M              (in_pl.m),
      .i_RD             (in_pl.rd),
      .i_saidaALU       (in_pl.alu),
      .i_entradaData    (in_pl.data),
      .o_out_valid      (ov4),
      .i_out_ready      (out_ready),
      .o_registradorWB  (wb4),
      .o_registradorM   (m4),
      .o_registradorRD  (rd4),
      .o_registradorALU (alu4),
      .o_saidaData      (dat4),
      .o_stall_count    (st4)
   );

   always #5 clk = ~clk;

   // Reference model state
   pl_t         q[$];
   int unsigned c16 = 0;
   int unsigned c4  = 0;
   bit          model_ok    = 1'b0;
   bit          last_accept = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [79:0] got,
                        input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic pl_t rand_pl();
      pl_t p;
      p.wb   = 2'($urandom);
      p.m    = 3'($urandom);
      p.rd   = 5'($urandom);
      p.alu  = $urandom;
      p.data = $urandom;
      return p;
   endfunction

   // One clock: compare at negedge, then advance the model across the posedge.
   task automatic tick();
      pl_t exp_pl;
      bit  exp_ov;
      bit  exp_ir;
      @(negedge clk);
      exp_ov = (q.size() > 0);
      exp_pl = exp_ov ? q[0] : '0;
      if (rst)       exp_ir = 1'b0;
      else if (SKID) exp_ir = (q.size() < 2);
      else           exp_ir = (q.size() == 0) || out_ready;
      if (model_ok) begin
         check("out_valid",    80'(ov16), 80'(exp_ov));
         check("payload",      80'({wb16, m16, rd16, alu16, dat16}), 80'(exp_pl));
         check("in_ready",     80'(ir16), 80'(exp_ir));
         check("stall16",      80'(st16), 80'(c16));
         check("c4_out_valid", 80'(ov4),  80'(exp_ov));
         check("c4_payload",   80'({wb4, m4, rd4, alu4, dat4}), 80'(exp_pl));
         check("c4_in_ready",  80'(ir4),  80'(exp_ir));
         check("stall4",       80'(st4),  80'(c4));
      end
      last_accept = in_valid && exp_ir && !rst && !flush;
      @(posedge clk);
      if (rst) begin
         q.delete();
         c16      = 0;
         c4       = 0;
         model_ok = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         if (exp_ov && !out_ready) begin
            if (c16 < 65535) c16++;
            if (c4 < 15)     c4++;
         end
         if (exp_ov && out_ready) void'(q.pop_front());
         if (in_valid && exp_ir) q.push_back(in_pl);
      end
      #1;
   endtask

   task automatic drive(input bit v, input bit ordy, input bit fl, input bit rs);
      in_valid  = v;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      tick();
   endtask

   pl_t items[4];
   int  idx;

   initial begin
      // Reset, then idle
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);

      // Stream 1,2,3 with out_ready high
      for (int i = 1; i <= 3; i++) begin
         in_pl     = rand_pl();
         in_pl.alu = 32'(i);
         drive(1, 1, 0, 0);
      end
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);

      // Stall 5 cycles offering A,B,C, then release
      for (int i = 0; i < 3; i++) items[i] = rand_pl();
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         in_pl = items[idx];
         drive(1, 0, 0, 0);
         if (last_accept && idx < 2) idx++;
      end
      for (int i = 0; i < 6; i++) begin
         in_pl = items[idx];
         drive(idx < 3, 1, 0, 0);
         if (last_accept) idx++;
      end
      check("abc_all_accepted", 80'(idx), 80'(3));

      // Flush while holding A (and B in skid) with D offered
      in_pl = rand_pl();
      drive(1, 0, 0, 0);
      in_pl = rand_pl();
      drive(1, 0, 0, 0);
      in_pl = rand_pl();
      drive(1, 0, 1, 0);
      drive(0, 0, 0, 0);
      check("flush_empty", 80'(ov16), 80'(0));

      // Saturation of the 4-bit counter
      in_pl = rand_pl();
      drive(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) drive(0, 0, 0, 0);
      check("stall4_saturated", 80'(st4), 80'(15));

      // Reset mid-stall with storage full, then drain
      in_pl = rand_pl();
      drive(1, 0, 0, 0);
      in_pl = rand_pl();
      drive(1, 0, 0, 1);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
      check("no_stale_after_reset", 80'(ov16), 80'(0));

      // Randomised traffic
      in_pl = rand_pl();
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, ($urandom % 10) < 7,
               ($urandom % 40) == 0, ($urandom % 150) == 0);
         if (last_accept) in_pl = rand_pl();
      end
      drive(0, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
